// File: rtl/lsu_mem_ctrl_pkg.sv
// ============================================================================
// Module   : lsu_mem_ctrl_pkg
// Brief    : Shared funct3 codes, FSM encoding and enable levels for the LSU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_mem_ctrl_pkg;

    localparam int c_DATA_W = 32;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // Memory enables are active low
    localparam logic c_WRITE_ENABLE = 1'b0;
    localparam logic c_READ_ENABLE  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RMW_RD = 2'd2,
        ST_WRITE  = 2'd3
    } state_e;

    function automatic logic f_funct3_legal(input logic i_we, input logic [2:0] i_f3);
        logic w_ok;
        w_ok = 1'b0;
        if (i_we) begin
            w_ok = (i_f3 == c_F3_B) || (i_f3 == c_F3_H) || (i_f3 == c_F3_W);
        end else begin
            w_ok = (i_f3 == c_F3_B) || (i_f3 == c_F3_H) || (i_f3 == c_F3_W) ||
                   (i_f3 == c_F3_BU) || (i_f3 == c_F3_HU);
        end
        return w_ok;
    endfunction

    // funct3[1:0] gives access size for both loads and stores
    function automatic logic f_misaligned(input logic [2:0] i_f3, input logic [1:0] i_off);
        logic w_bad;
        w_bad = 1'b0;
        if (i_f3[1:0] == 2'b01) begin
            w_bad = i_off[0];
        end else if (i_f3[1:0] == 2'b10) begin
            w_bad = (i_off != 2'b00);
        end
        return w_bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_ctrl_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Load lane extract/extend and store lane merge (combinational).
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_off,
    input  logic [DATA_W-1:0] i_rword,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic [DATA_W-1:0] o_merge_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];
    end

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            c_F3_B:  o_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_F3_H:  o_load_data = {{(DATA_W-16){w_half[15]}}, w_half};
            c_F3_W:  o_load_data = i_rword;
            c_F3_BU: o_load_data = {{(DATA_W-8){1'b0}}, w_byte};
            c_F3_HU: o_load_data = {{(DATA_W-16){1'b0}}, w_half};
            default: o_load_data = '0;
        endcase
    end

    // Sub-word stores keep the untouched lanes from the word just read
    always_comb begin
        o_merge_word = i_rword;
        case (i_funct3)
            c_F3_B: begin
                case (i_off)
                    2'd0:    o_merge_word[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge_word[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge_word[23:16] = i_wdata[7:0];
                    default: o_merge_word[31:24] = i_wdata[7:0];
                endcase
            end
            c_F3_H: begin
                if (i_off[1]) begin
                    o_merge_word[31:16] = i_wdata[15:0];
                end else begin
                    o_merge_word[15:0] = i_wdata[15:0];
                end
            end
            default: o_merge_word = i_wdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : MEM-stage load/store controller with read-modify-write sub-word stores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int MEM_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              mem_wrn,
    output logic              mem_rdn
);

    state_e              r_state_q,  w_state_d;
    logic [MEM_AW+1:0]   r_addr_q,   w_addr_d;
    logic [DATA_W-1:0]   r_wdata_q,  w_wdata_d;
    logic [2:0]          r_funct3_q, w_funct3_d;
    logic [4:0]          r_rd_q,     w_rd_d;
    logic [DATA_W-1:0]   r_merge_q,  w_merge_d;
    logic                r_resp_valid_q, w_resp_valid_d;
    logic                r_resp_err_q,   w_resp_err_d;
    logic [DATA_W-1:0]   r_resp_rdata_q, w_resp_rdata_d;
    logic [4:0]          r_resp_rd_q,    w_resp_rd_d;

    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_merge_word;
    logic                w_illegal;

    // Address bits above the word index wrap and are deliberately dropped
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = &{1'b0, req_addr[DATA_W-1:MEM_AW+2]};

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_funct3     (r_funct3_q),
        .i_off        (r_addr_q[1:0]),
        .i_rword      (mem_dout),
        .i_wdata      (r_wdata_q),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    assign w_illegal = !f_funct3_legal(req_we, req_funct3) ||
                       f_misaligned(req_funct3, req_addr[1:0]);

    always_comb begin
        w_state_d      = r_state_q;
        w_addr_d       = r_addr_q;
        w_wdata_d      = r_wdata_q;
        w_funct3_d     = r_funct3_q;
        w_rd_d         = r_rd_q;
        w_merge_d      = r_merge_q;
        w_resp_valid_d = 1'b0;
        w_resp_err_d   = 1'b0;
        w_resp_rdata_d = '0;
        w_resp_rd_d    = r_resp_rd_q;

        case (r_state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    w_addr_d   = req_addr[MEM_AW+1:0];
                    w_wdata_d  = req_wdata;
                    w_funct3_d = req_funct3;
                    w_rd_d     = req_rd;
                    if (w_illegal) begin
                        w_resp_valid_d = 1'b1;
                        w_resp_err_d   = 1'b1;
                        w_resp_rd_d    = req_rd;
                    end else if (!req_we) begin
                        w_state_d = ST_LOAD;
                    end else if (req_funct3 == c_F3_W) begin
                        w_merge_d = req_wdata;
                        w_state_d = ST_WRITE;
                    end else begin
                        w_state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                w_resp_valid_d = 1'b1;
                w_resp_rdata_d = w_load_data;
                w_resp_rd_d    = r_rd_q;
                w_state_d      = ST_IDLE;
            end
            ST_RMW_RD: begin
                w_merge_d = w_merge_word;
                w_state_d = ST_WRITE;
            end
            ST_WRITE: begin
                w_resp_valid_d = 1'b1;
                w_resp_rd_d    = r_rd_q;
                w_state_d      = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q      <= ST_IDLE;
            r_addr_q       <= '0;
            r_wdata_q      <= '0;
            r_funct3_q     <= '0;
            r_rd_q         <= '0;
            r_merge_q      <= '0;
            r_resp_valid_q <= 1'b0;
            r_resp_err_q   <= 1'b0;
            r_resp_rdata_q <= '0;
            r_resp_rd_q    <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_addr_q       <= w_addr_d;
            r_wdata_q      <= w_wdata_d;
            r_funct3_q     <= w_funct3_d;
            r_rd_q         <= w_rd_d;
            r_merge_q      <= w_merge_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_err_q   <= w_resp_err_d;
            r_resp_rdata_q <= w_resp_rdata_d;
            r_resp_rd_q    <= w_resp_rd_d;
        end
    end

    assign req_ready  = (r_state_q == ST_IDLE);
    assign resp_valid = r_resp_valid_q;
    assign resp_err   = r_resp_err_q;
    assign resp_rdata = r_resp_rdata_q;
    assign resp_rd    = r_resp_rd_q;

    assign mem_addr = r_addr_q[MEM_AW+1:2];
    assign mem_din  = (r_state_q == ST_WRITE) ? r_merge_q : '0;
    assign mem_rdn  = ((r_state_q == ST_LOAD) || (r_state_q == ST_RMW_RD)) ?
                      c_READ_ENABLE : ~c_READ_ENABLE;
    // Reset gates the write strobe combinationally so an in-flight write is dropped
    assign mem_wrn  = ((r_state_q == ST_WRITE) && !RST) ?
                      c_WRITE_ENABLE : ~c_WRITE_ENABLE;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Brief    : Directed vector bench for lsu_mem_ctrl with a behavioural memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_ctrl;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [4:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_wrn;
    logic        mem_rdn;

    int n_checks = 0;
    int n_pass   = 0;

    bit [31:0] tb_mem [32];

    lsu_mem_ctrl #(
        .DATA_W (32),
        .MEM_AW (5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_wrn    (mem_wrn),
        .mem_rdn    (mem_rdn)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_dout = tb_mem[mem_addr];
    always @(posedge CLK) begin
        if (!mem_wrn) tb_mem[mem_addr] <= mem_din;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          wr;
    } vec_t;

    vec_t tv [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one request from a negedge and wait for its response
    task automatic do_req(input int idx, input vec_t v);
        int w;
        int lat;
        int wr;
        bit got;
        string tag;
        tag = $sformatf("v%0d", idx);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge CLK);
            w++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        lat = 0;
        wr  = 0;
        got = 1'b0;
        while (lat < 10 && !got) begin
            @(negedge CLK);
            lat++;
            if (!mem_wrn) wr++;
            if (resp_valid) got = 1'b1;
        end
        chk({tag, "_lat"},   lat,        v.lat);
        chk({tag, "_err"},   {31'd0, resp_err}, {31'd0, v.err});
        chk({tag, "_rdata"}, resp_rdata, v.rdata);
        chk({tag, "_rd"},    {27'd0, resp_rd},  {27'd0, v.rd});
        chk({tag, "_writes"}, wr,        v.wr);
    endtask

    initial begin
        //          we    f3      addr   wdata         rd  err rdata         lat wr
        tv[0]  = '{1'b1, 3'b010, 32'h8,  32'hDEADBEEF, 5'd1,  1'b0, 32'h0,          2, 1};
        tv[1]  = '{1'b0, 3'b010, 32'h8,  32'h0,        5'd2,  1'b0, 32'hDEADBEEF,   2, 0};
        tv[2]  = '{1'b1, 3'b010, 32'h8,  32'h11223344, 5'd3,  1'b0, 32'h0,          2, 1};
        tv[3]  = '{1'b1, 3'b000, 32'hA,  32'hFFFFFFAB, 5'd4,  1'b0, 32'h0,          3, 1};
        tv[4]  = '{1'b0, 3'b010, 32'h8,  32'h0,        5'd5,  1'b0, 32'h11AB3344,   2, 0};
        tv[5]  = '{1'b1, 3'b010, 32'h8,  32'h80FF7F01, 5'd6,  1'b0, 32'h0,          2, 1};
        tv[6]  = '{1'b0, 3'b000, 32'hB,  32'h0,        5'd7,  1'b0, 32'hFFFFFF80,   2, 0};
        tv[7]  = '{1'b0, 3'b100, 32'hB,  32'h0,        5'd8,  1'b0, 32'h00000080,   2, 0};
        tv[8]  = '{1'b0, 3'b001, 32'h8,  32'h0,        5'd9,  1'b0, 32'h00007F01,   2, 0};
        tv[9]  = '{1'b0, 3'b101, 32'hA,  32'h0,        5'd10, 1'b0, 32'h000080FF,   2, 0};
        tv[10] = '{1'b0, 3'b010, 32'h6,  32'h0,        5'd11, 1'b1, 32'h0,          1, 0};
        tv[11] = '{1'b1, 3'b001, 32'h5,  32'h5555AAAA, 5'd12, 1'b1, 32'h0,          1, 0};
        tv[12] = '{1'b0, 3'b010, 32'h8,  32'h0,        5'd13, 1'b0, 32'h80FF7F01,   2, 0};
        tv[13] = '{1'b0, 3'b011, 32'h8,  32'h0,        5'd14, 1'b1, 32'h0,          1, 0};
        tv[14] = '{1'b1, 3'b100, 32'h8,  32'h12345678, 5'd15, 1'b1, 32'h0,          1, 0};
        tv[15] = '{1'b1, 3'b001, 32'h8,  32'h1234CAFE, 5'd16, 1'b0, 32'h0,          3, 1};
        tv[16] = '{1'b0, 3'b010, 32'h88, 32'h0,        5'd17, 1'b0, 32'h80FFCAFE,   2, 0};
        tv[17] = '{1'b1, 3'b000, 32'h1,  32'h00000055, 5'd18, 1'b0, 32'h0,          3, 1};
        tv[18] = '{1'b0, 3'b001, 32'hA,  32'h0,        5'd19, 1'b0, 32'hFFFF80FF,   2, 0};
        tv[19] = '{1'b1, 3'b010, 32'h4,  32'h0BADF00D, 5'd20, 1'b0, 32'h0,          2, 1};
        tv[20] = '{1'b1, 3'b010, 32'h0,  32'hAAAA5555, 5'd21, 1'b0, 32'h0,          2, 1};

        RST = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_rd = 5'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        chk("rst_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_valid",  {31'd0, resp_valid}, 32'd0);
        chk("rst_err",    {31'd0, resp_err},   32'd0);
        chk("rst_rdata",  resp_rdata,          32'd0);
        chk("rst_rd",     {27'd0, resp_rd},    32'd0);
        chk("rst_wrn",    {31'd0, mem_wrn},    32'd1);
        chk("rst_rdn",    {31'd0, mem_rdn},    32'd1);
        chk("rst_maddr",  {27'd0, mem_addr},   32'd0);
        chk("rst_mdin",   mem_din,             32'd0);

        for (int i = 0; i < 21; i++) begin
            do_req(i, tv[i]);
        end
        chk("sb_lane1_mem", tb_mem[0], 32'hAAAA5555);

        // Reset while a SW is in its WRITE cycle
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h0;
        req_wdata = 32'h12345678;
        req_rd = 5'd22;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        chk("wr_state_wrn", {31'd0, mem_wrn}, 32'd0);
        RST = 1'b1;
        #1;
        chk("rstwr_wrn", {31'd0, mem_wrn}, 32'd1);
        @(posedge CLK);
        #1;
        chk("rstwr_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstwr_ready", {31'd0, req_ready},  32'd1);
        chk("rstwr_rdn",   {31'd0, mem_rdn},    32'd1);
        chk("rstwr_maddr", {27'd0, mem_addr},   32'd0);
        chk("rstwr_mdin",  mem_din,             32'd0);
        chk("rstwr_mem0",  tb_mem[0],           32'hAAAA5555);
        @(negedge CLK);
        RST = 1'b0;
        chk("rstwr_post_valid", {31'd0, resp_valid}, 32'd0);
        do_req(21, '{1'b0, 3'b010, 32'h0, 32'h0, 5'd23, 1'b0, 32'hAAAA5555, 2, 0});

        // Back-to-back loads with req_valid held high
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h0;
        req_rd = 5'd7;
        @(posedge CLK);
        @(negedge CLK);
        chk("b2b_busy", {31'd0, req_ready}, 32'd0);
        req_addr = 32'h4;
        req_rd = 5'd9;
        @(negedge CLK);
        chk("b2b_v1",     {31'd0, resp_valid}, 32'd1);
        chk("b2b_ready1", {31'd0, req_ready},  32'd1);
        chk("b2b_rd1",    {27'd0, resp_rd},    32'd7);
        chk("b2b_data1",  resp_rdata,          32'hAAAA5555);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_gap", {31'd0, resp_valid}, 32'd0);
        @(negedge CLK);
        chk("b2b_v2",    {31'd0, resp_valid}, 32'd1);
        chk("b2b_rd2",   {27'd0, resp_rd},    32'd9);
        chk("b2b_data2", resp_rdata,          32'h0BADF00D);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
